fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the pipelined RV32I core. Holds the PC, issues one instruction-memory request at a time, and buffers returned instructions. It presents {pc, inst} to the decode stage, where the immediate generator and control unit consume `id_inst`. Redirects from EX (taken branch, JALR, mispredict) flush all fetched-but-undelivered work.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `redirect_valid`  in  1  EX-stage redirect request.
- `redirect_pc`  in  32  redirect target.
- `imem_req_valid`  out  1  fetch request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  fetch address.
- `imem_resp_valid`  in  1  response valid (≥1 cycle after acceptance).
- `imem_resp_inst`  in  32  returned instruction word.
- `id_valid`  out  1  decode-side output valid.
- `id_ready`  in  1  decode accepts output.
- `id_pc`  out  32  PC of `id_inst`.
- `id_inst`  out  32  instruction to decode.
- `id_pred_taken`  out  1  fetch predicted this instruction taken.

## Operation
- State: `pc`, `req_pc` (outstanding address), `state` ∈ {S_REQ, S_WAIT}, `drop`, output register (`id_*`), 1-entry skid buffer (`buf_valid`, `buf_pc`, `buf_inst`, `buf_pred`).
- S_REQ: `imem_req_valid = !buf_valid`, `imem_req_addr = pc`. On handshake: `req_pc <= pc`, `pc <= pc + 4` (32-bit wrap), go S_WAIT.
- S_WAIT: `imem_req_valid = 0`. On `imem_resp_valid`:
  - If `drop`: discard the word, clear `drop`, go S_REQ.
  - Otherwise, load the output register if it is empty or consumed this cycle; else load the buffer. Go S_REQ.
- Output handshake: `id_valid && id_ready` consumes the output. The buffer moves into the output register on the same edge if it is valid.
- Only one request is outstanding. No request is issued while the buffer is full.
- Redirect (highest priority):
  - `pc <= redirect_pc`.
  - Output register and buffer are invalidated.
  - `state <= S_REQ`.
  - `drop <= 1` if a request is in S_WAIT without a response this cycle, or a request handshake occurs this same cycle. Otherwise `drop <= 0`.
  - A response arriving in the redirect cycle is discarded.
- Redirect and `id_ready` in the same cycle: the output counts as consumed, then it is invalidated.

## Timing
- Reset values: `pc = RESET_PC`, `state = S_REQ`, `drop = 0`, `id_valid = 0`, `id_pc = 0`, `id_inst = 0`, `id_pred_taken = 0`, `buf_valid = 0`.
- `imem_req_valid = 0` during the reset cycle and asserts the first cycle after reset is released.
- Reset mid-transaction: the in-flight response is ignored only if it arrives during reset. Memory must be quiescent at reset release.
- Latency: request accepted at cycle t, response at t+k, so `id_valid` = 1 at t+k+1. Next request issues at t+k+1 at the earliest.
- First fetch after a redirect: request at cycle r+1.
- `id_*` are registered outputs. `imem_req_*` are combinational from `state` and `buf_valid` only, with no path from `redirect_valid`.

## Configuration
- `FETCH_JAL_PREDICT_EN`:
  - Defined: when a non-dropped response has opcode 7'b1101111 (JAL), `pc <= req_pc + jimm` instead of the incremented value. `jimm` = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}. The instruction carries `id_pred_taken = 1`. A redirect in the same cycle overrides the prediction.
  - Undefined: `id_pred_taken` is tied to 0, and JAL is resolved by EX redirect.

## Structure
- Shared package `riscv_pkg`:
  - Opcode constants (`OPC_JAL = 7'b1101111`, the others the decode stage uses).
  - `NOP_INST = 32'h0000_0013`, for consumers only.
  - Default `RESET_PC`.
  - State enum `fetch_state_t`.
- Sub-module `jal_predecode`: combinational; in: inst, pc; out: is_jal, target. Instantiated only under `FETCH_JAL_PREDICT_EN`.

## Test plan
- Reset release; memory always ready; k=1; `id_ready` = 1.
  - `imem_req_addr` = 0x0, 0x4, 0x8 at cycles 1, 3, 5.
  - `id_pc` = 0x0 with `id_valid` at cycle 3.
- `id_ready` = 0 for 10 cycles.
  - Output holds 0x0, buffer captures 0x4, and no further requests issue.
  - On release: 0x0, then 0x4 delivered back-to-back.
- Redirect to 0x100 while a request to 0x8 is in S_WAIT (k=3).
  - The 0x8 response is dropped.
  - Next request address is 0x100.
  - `id_pc` never shows 0x8.
- Redirect in the same cycle as `imem_resp_valid`.
  - The word is discarded, `drop` stays 0, and the request to the redirect target is issued the next cycle.
- With macro: response at pc 0x10, inst 0x0080006F (jal x0, +8).
  - Next `imem_req_addr` = 0x18, and `id_pred_taken` = 1.
- Without macro, same stimulus.
  - Next address = 0x14, and `id_pred_taken` = 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, reset defaults and the fetch-stage state/entry types.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // addi x0, x0, 0 -- for consumers that need a bubble
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } fetch_entry_t;

    function automatic logic [31:0] jal_imm(input logic [31:0] i);
        return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: EX redirect, instruction-memory request/response and decode handoff.
interface fetch_stage_if;

    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_inst;

    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_pred_taken;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_req_ready, imem_resp_valid, imem_resp_inst,
        input  id_ready,
        output imem_req_valid, imem_req_addr,
        output id_valid, id_pc, id_inst, id_pred_taken
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_req_ready, imem_resp_valid, imem_resp_inst,
        output id_ready,
        input  imem_req_valid, imem_req_addr,
        input  id_valid, id_pc, id_inst, id_pred_taken
    );

endinterface

// File: rtl/fetch_stage_jal_predecode.sv
// JAL predecoder: flags a JAL word and computes its target. Used only with FETCH_JAL_PREDICT_EN.
module jal_predecode
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    input  logic [31:0] pc,
    output logic        is_jal,
    output logic [31:0] target
);

    assign is_jal = (inst[6:0] == OPC_JAL);
    assign target = pc + jal_imm(inst);

endmodule

// File: rtl/fetch_stage.sv
// RV32I fetch stage: PC, single outstanding imem request, output register plus 1-entry skid buffer.
// Optional static JAL prediction is compiled in with `define FETCH_JAL_PREDICT_EN.
module fetch_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master bus
);

    fetch_state_t state, state_n;
    logic [31:0]  pc, pc_n, req_pc;
    logic         drop, drop_n;
    fetch_entry_t out_q, buf_q, resp_entry;
    logic         out_valid, buf_valid;

    logic         req_fire, resp_keep, resp_ack;
    logic         consume, out_free, pred_hit;
    logic [1:0]   stale_cnt;

    // Request side depends only on state/buffer occupancy, never on redirect.
    assign bus.imem_req_valid = !rst && (state == S_REQ) && !buf_valid;
    assign bus.imem_req_addr  = pc;

    assign req_fire  = bus.imem_req_valid && bus.imem_req_ready;
    assign resp_keep = bus.imem_resp_valid && (state == S_WAIT) && !drop;
    assign resp_ack  = bus.imem_resp_valid && ((state == S_WAIT) || drop);
    assign consume   = out_valid && bus.id_ready;
    assign out_free  = !out_valid || consume;

`ifdef FETCH_JAL_PREDICT_EN
    logic [31:0] jal_target;

    jal_predecode u_predecode (
        .inst   (bus.imem_resp_inst),
        .pc     (req_pc),
        .is_jal (pred_hit),
        .target (jal_target)
    );
`else
    assign pred_hit = 1'b0;
`endif

    assign resp_entry = '{pc: req_pc, inst: bus.imem_resp_inst, pred: pred_hit};

    always_comb begin
        pc_n = pc;
        if (req_fire)
            pc_n = pc + 32'd4;
`ifdef FETCH_JAL_PREDICT_EN
        else if (resp_keep && pred_hit)
            pc_n = jal_target;
`endif
        if (bus.redirect_valid)
            pc_n = bus.redirect_pc;
    end

    // Responses still owed by memory once this edge retires; all become stale on redirect.
    assign stale_cnt = {1'b0, drop} + {1'b0, state == S_WAIT} + {1'b0, req_fire}
                     - {1'b0, resp_ack};

    always_comb begin
        state_n = state;
        drop_n  = drop;
        if (bus.redirect_valid) begin
            state_n = S_REQ;
            drop_n  = (stale_cnt != 2'd0);
        end else begin
            if (drop && bus.imem_resp_valid)
                drop_n = 1'b0;
            case (state)
                S_REQ:   if (req_fire)  state_n = S_WAIT;
                S_WAIT:  if (resp_keep) state_n = S_REQ;
                default: state_n = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc        <= RESET_PC;
            req_pc    <= RESET_PC;
            out_valid <= 1'b0;
            out_q     <= '0;
            buf_valid <= 1'b0;
            buf_q     <= '0;
        end else begin
            pc <= pc_n;
            if (req_fire)
                req_pc <= pc;

            if (bus.redirect_valid) begin
                out_valid <= 1'b0;
                buf_valid <= 1'b0;
            end else if (out_free) begin
                // Buffered word is older than any new response, so it goes out first.
                if (buf_valid) begin
                    out_q     <= buf_q;
                    out_valid <= 1'b1;
                    buf_valid <= resp_keep;
                    if (resp_keep)
                        buf_q <= resp_entry;
                end else begin
                    out_valid <= resp_keep;
                    if (resp_keep)
                        out_q <= resp_entry;
                end
            end else if (resp_keep) begin
                buf_valid <= 1'b1;
                buf_q     <= resp_entry;
            end
        end
    end

    assign bus.id_valid      = out_valid;
    assign bus.id_pc         = out_q.pc;
    assign bus.id_inst       = out_q.inst;
    assign bus.id_pred_taken = out_q.pred;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed timing scenarios plus randomized traffic against a
// program-order scoreboard (expected PC stream derived from memory contents and redirects).
module tb_fetch_stage;
    import riscv_pkg::*;

`ifdef FETCH_JAL_PREDICT_EN
    localparam bit PRED_EN = 1'b1;
`else
    localparam bit PRED_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_stage_if bus();

    fetch_stage #(.RESET_PC(32'h0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          deliveries = 0;
    logic [31:0] exp_q[$];
    mreq_t       pend[$];
    logic        mem_single = 1'b0;
    int          mem_k = 1;
    logic        d_rst = 1'b1, d_rdy = 1'b1, d_redir = 1'b0;
    logic [31:0] d_rpc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h10) return 32'h0080_006F;
        h = (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
        if (a >= 32'h400 && h[3:0] == 4'h0) return {h[31:7], 7'b1101111};
        return {h[31:7], 7'b0010011};
    endfunction

    function automatic logic is_jal(input logic [31:0] i);
        return i[6:0] == 7'b1101111;
    endfunction

    // Program order: next PC is pc+4, or the JAL target when prediction is built in.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] i);
        int off;
        if (PRED_EN && is_jal(i)) begin
            off = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            return pc + off;
        end
        return pc + 32'd4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One cycle: drive at negedge, record request handshake, then update the model.
    task automatic step();
        logic [31:0] junk;
        @(negedge clk);
        cyc++;
        rst                = d_rst;
        bus.id_ready       = d_rdy;
        bus.redirect_valid = d_redir;
        bus.redirect_pc    = d_rpc;
        if (!d_rst && pend.size() > 0 && pend[0].due <= cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_inst  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            junk = $urandom;
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_inst  = junk;
        end
        bus.imem_req_ready = mem_single ? (pend.size() == 0 && ($urandom % 4 != 0)) : 1'b1;
        #1;
        if (bus.imem_req_valid && bus.imem_req_ready)
            pend.push_back('{addr: bus.imem_req_addr,
                             due:  cyc + (mem_single ? int'($urandom_range(1, 4)) : mem_k)});
        #2;
        if (d_rst) begin
            exp_q.delete();
            exp_q.push_back(32'h0);
            pend.delete();
        end else if (d_redir) begin
            exp_q.delete();
            exp_q.push_back(d_rpc);
        end
    endtask

    task automatic do_reset();
        d_rst   = 1'b1;
        d_redir = 1'b0;
        cyc     = -3;
        repeat (3) step();
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_id_valid", bus.id_valid, 0);
        check("rst_id_pc", bus.id_pc, 0);
        check("rst_id_inst", bus.id_inst, 0);
        check("rst_id_pred", bus.id_pred_taken, 0);
        d_rst = 1'b0;
    endtask

    // Monitor: every accepted decode-side word must be the next one in program order.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && bus.id_valid === 1'b1 && bus.id_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL deliver: got pc %h, expected nothing", bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", bus.id_pc, e);
                    check("id_inst", bus.id_inst, mem_word(e));
                    check("id_pred", bus.id_pred_taken, PRED_EN && is_jal(mem_word(e)));
                    exp_q.push_back(model_next(e, mem_word(e)));
                    deliveries++;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] tmp;
        int          d0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = 32'h0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_inst  = 32'h0;
        bus.id_ready        = 1'b1;

        // k=1, always ready: requests every other cycle, JAL at 0x10
        mem_single = 1'b0;
        mem_k      = 1;
        d_rdy      = 1'b1;
        do_reset();
        for (int c = 1; c <= 11; c++) begin
            step();
            if (c % 2 == 1) begin
                check("req_valid_odd", bus.imem_req_valid, 1);
                if (c == 11) check("req_addr_after_jal", bus.imem_req_addr, PRED_EN ? 32'h18 : 32'h14);
                else         check("req_addr", bus.imem_req_addr, 32'((c - 1) * 2));
            end else begin
                check("req_valid_even", bus.imem_req_valid, 0);
            end
            if (c == 3) begin
                check("first_id_valid", bus.id_valid, 1);
                check("first_id_pc", bus.id_pc, 32'h0);
            end
            if (c == 11) begin
                check("jal_id_pc", bus.id_pc, 32'h10);
                check("jal_pred", bus.id_pred_taken, PRED_EN);
            end
        end

        // Decode stalls for 10 cycles: buffer fills, requests stop
        do_reset();
        for (int c = 1; c <= 13; c++) begin
            d_rdy = (c >= 11);
            step();
            if (c >= 5 && c <= 10) check("stall_no_req", bus.imem_req_valid, 0);
            if (c == 10) begin
                check("stall_id_valid", bus.id_valid, 1);
                check("stall_id_pc", bus.id_pc, 32'h0);
            end
            if (c == 11) check("release_id_pc0", bus.id_pc, 32'h0);
            if (c == 12) begin
                check("release_id_valid", bus.id_valid, 1);
                check("release_id_pc4", bus.id_pc, 32'h4);
                check("release_req_addr", bus.imem_req_addr, 32'h8);
                check("release_req_valid", bus.imem_req_valid, 1);
            end
        end

        // k=3: redirect while 0x8 is outstanding, then redirect alongside a response
        mem_k = 3;
        d_rdy = 1'b1;
        do_reset();
        for (int c = 1; c <= 20; c++) begin
            d_redir = (c == 10 || c == 14);
            d_rpc   = (c == 10) ? 32'h100 : 32'h200;
            step();
            if (c == 11) begin
                check("redir_req_valid", bus.imem_req_valid, 1);
                check("redir_req_addr", bus.imem_req_addr, 32'h100);
            end
            if (c == 13) check("dropped_no_id", bus.id_valid, 0);
            if (c == 15) begin
                check("redir2_req_valid", bus.imem_req_valid, 1);
                check("redir2_req_addr", bus.imem_req_addr, 32'h200);
                check("redir2_no_id", bus.id_valid, 0);
            end
            if (c == 19) begin
                check("redir2_id_valid", bus.id_valid, 1);
                check("redir2_id_pc", bus.id_pc, 32'h200);
            end
        end
        d_redir = 1'b0;

        // Random traffic: variable latency, backpressure and redirects
        mem_single = 1'b1;
        do_reset();
        d0 = deliveries;
        for (int c = 0; c < 4000; c++) begin
            d_rdy   = ($urandom % 3 != 0);
            d_redir = ($urandom % 24 == 0);
            tmp     = $urandom;
            d_rpc   = {tmp[31:2], 2'b00};
            step();
        end
        d_redir = 1'b0;
        d_rdy   = 1'b1;
        check("random_progress", 32'(deliveries - d0 >= 200), 1);
        d0 = deliveries;
        repeat (40) step();
        check("drain_progress", 32'(deliveries > d0), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
